// File: rtl/stopwatch_fnd_ctrl.sv
// stopwatch_fnd_ctrl: frame-coherent 4-digit common-anode 7-seg scanner for stopwatch time (SS.CC / HH.MM).
// Define LEADING_ZERO_BLANK_EN to blank a zero leftmost digit.
module stopwatch_fnd_ctrl #(
    parameter int SCAN_COUNT = 100_000,
    parameter int DOT_HALF   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       i_mode,
    output logic [3:0] o_fnd_comm,
    output logic [7:0] o_fnd_font
);
    localparam int CW = $clog2(SCAN_COUNT);

    logic [CW-1:0] scan_cnt;
    logic          scan_tick;
    logic [1:0]    sel;
    logic [6:0]    snap_msec;
    logic [5:0]    snap_sec;
    logic [5:0]    snap_min;
    logic [4:0]    snap_hour;
    logic          snap_mode;
    logic [15:0]   digits;
    logic [3:0]    dig;
    logic [7:0]    font;

    // A value above 99 cannot be shown as two digits, so both halves go blank.
    function automatic logic [7:0] split(input logic [6:0] v);
        return v > 7'd99 ? 8'hFF : {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    assign scan_tick = scan_cnt == CW'(SCAN_COUNT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            sel      <= '0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
            if (scan_tick) sel <= sel + 1'b1;
        end
    end

    // Snapshot on the last-digit tick so the new frame starts with fresh, coherent values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_msec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
            snap_mode <= 1'b0;
        end else if (scan_tick && sel == 2'd3) begin
            snap_msec <= i_msec;
            snap_sec  <= i_sec;
            snap_min  <= i_min;
            snap_hour <= i_hour;
            snap_mode <= i_mode;
        end
    end

    always_comb begin
        digits = {snap_mode ? split({2'b00, snap_hour}) : split({1'b0, snap_sec}),
                  snap_mode ? split({1'b0, snap_min})   : split(snap_msec)};
        dig    = digits[{sel, 2'b00} +: 4];
        font   = seg(dig);
`ifdef LEADING_ZERO_BLANK_EN
        if (sel == 2'd3 && dig == 4'd0) font = 8'hFF;
`endif
        if (sel == 2'd2 && snap_msec < 7'(DOT_HALF)) font[7] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_fnd_comm <= 4'hF;
            o_fnd_font <= 8'hFF;
        end else begin
            o_fnd_comm <= ~(4'b0001 << sel);
            o_fnd_font <= font;
        end
    end
endmodule

// File: tb/tb_stopwatch_fnd_ctrl.sv
// tb_stopwatch_fnd_ctrl: directed scenarios plus randomized traffic against a cycle-indexed reference model.
module tb_stopwatch_fnd_ctrl;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [6:0] i_msec = '0;
    logic [5:0] i_sec  = '0;
    logic [5:0] i_min  = '0;
    logic [4:0] i_hour = '0;
    logic       i_mode = 1'b0;
    logic [3:0] o_fnd_comm;
    logic [7:0] o_fnd_font;
    int n_cmp = 0;
    int n_err = 0;

    stopwatch_fnd_ctrl #(.SCAN_COUNT(4), .DOT_HALF(50)) dut (
        .clk(clk), .reset(reset), .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min),
        .i_hour(i_hour), .i_mode(i_mode), .o_fnd_comm(o_fnd_comm), .o_fnd_font(o_fnd_font)
    );

    always #5 clk = ~clk;

    // Reference: edge t after reset shows digit (t/4)%4 of the values captured at the last edge with t%16==15.
    int t = 0;
    int m_msec = 0, m_sec = 0, m_min = 0, m_hour = 0;
    bit m_mode = 1'b0;
    logic [3:0] exp_comm = 4'hF;
    logic [7:0] exp_font = 8'hFF;
    logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [7:0] ref_font(int s, int ms, int sc, int mn, int hr, bit md);
        int v, d;
        logic [7:0] f;
        v = (s >= 2) ? (md ? hr : sc) : (md ? mn : ms);
        d = (v > 99) ? 10 : ((s % 2 == 1) ? v / 10 : v % 10);
        f = (d > 9) ? 8'hFF : font_tab[d];
        if (LZB && s == 3 && d == 0) f = 8'hFF;
        if (s == 2 && ms < 50) f[7] = 1'b0;
        return f;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t <= 0;
            m_msec <= 0; m_sec <= 0; m_min <= 0; m_hour <= 0; m_mode <= 1'b0;
            exp_comm <= 4'hF;
            exp_font <= 8'hFF;
        end else begin
            exp_comm <= ~(4'(1) << ((t / 4) % 4));
            exp_font <= ref_font((t / 4) % 4, m_msec, m_sec, m_min, m_hour, m_mode);
            if (t % 16 == 15) begin
                m_msec <= int'(i_msec); m_sec <= int'(i_sec); m_min <= int'(i_min);
                m_hour <= int'(i_hour); m_mode <= i_mode;
            end
            t <= t + 1;
        end
    end

    task automatic wait_frame();
        int g = 0;
        do begin @(negedge clk); g++; end while (t % 16 != 0 && g < 40);
        n_cmp++;
        if (t % 16 != 0) begin n_err++; $display("FAIL frame_wait: phase=%0d required 0", t % 16); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (o_fnd_comm !== 4'hF || o_fnd_font !== 8'hFF) begin
                n_err++; $display("FAIL reset_dark: comm=%b font=%h required 1111 ff", o_fnd_comm, o_fnd_font);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_fnd_comm !== 4'b1110 || o_fnd_font !== 8'hC0) begin
            n_err++; $display("FAIL first_digit: comm=%b font=%h required 1110 c0", o_fnd_comm, o_fnd_font);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (o_fnd_comm !== 4'b1101 || o_fnd_font !== 8'hC0) begin
            n_err++; $display("FAIL after_tick: comm=%b font=%h required 1101 c0", o_fnd_comm, o_fnd_font);
        end
    endtask

    task automatic check_frame(string name, logic [7:0] ef [4]);
        logic [3:0] ec [4];
        ec = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o_fnd_comm !== ec[k] || o_fnd_font !== ef[k]) begin
                n_err++;
                $display("FAIL %s_d%0d: comm=%b font=%h required %b %h", name, k, o_fnd_comm, o_fnd_font, ec[k], ef[k]);
            end
            n_cmp++;
            if (o_fnd_comm !== exp_comm || o_fnd_font !== exp_font) begin
                n_err++;
                $display("FAIL %s_model_d%0d: comm=%b font=%h required %b %h", name, k, o_fnd_comm, o_fnd_font, exp_comm, exp_font);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_mode0();
        logic [7:0] ef [4];
        ef = '{8'hA4, 8'h99, 8'h78, 8'hB0};
        i_mode = 1'b0; i_sec = 6'd37; i_msec = 7'd42;
        wait_frame();
        check_frame("mode0", ef);
    endtask

    task automatic test_mode1();
        logic [7:0] ef [4];
        ef = '{8'h90, 8'hC0, 8'h12, LZB ? 8'hFF : 8'hC0};
        i_mode = 1'b1; i_hour = 5'd5; i_min = 6'd9; i_msec = 7'd42;
        wait_frame();
        check_frame("mode1", ef);
        ef = '{8'h90, 8'hC0, 8'h92, LZB ? 8'hFF : 8'hC0};
        i_msec = 7'd77;
        wait_frame();
        check_frame("mode1_nodot", ef);
    endtask

    task automatic test_midframe();
        i_mode = 1'b0; i_sec = 6'd37; i_msec = 7'd42;
        wait_frame();
        repeat (5) @(negedge clk);
        i_sec = 6'd38;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (o_fnd_comm !== 4'b1011 || o_fnd_font !== 8'h78) begin
            n_err++; $display("FAIL midframe_hold: comm=%b font=%h required 1011 78", o_fnd_comm, o_fnd_font);
        end
        wait_frame();
        repeat (9) @(negedge clk);
        n_cmp++;
        if (o_fnd_comm !== 4'b1011 || o_fnd_font !== 8'h00) begin
            n_err++; $display("FAIL midframe_next: comm=%b font=%h required 1011 00", o_fnd_comm, o_fnd_font);
        end
    endtask

    task automatic test_dot_and_range();
        i_mode = 1'b0; i_sec = 6'd37; i_msec = 7'd49;
        wait_frame();
        repeat (9) @(negedge clk);
        n_cmp++;
        if (o_fnd_font !== 8'h78) begin n_err++; $display("FAIL dot_49: font=%h required 78", o_fnd_font); end
        i_msec = 7'd50;
        wait_frame();
        repeat (9) @(negedge clk);
        n_cmp++;
        if (o_fnd_font !== 8'hF8) begin n_err++; $display("FAIL dot_50: font=%h required f8", o_fnd_font); end
        i_msec = 7'd120;
        wait_frame();
        @(negedge clk);
        n_cmp++;
        if (o_fnd_comm !== 4'b1110 || o_fnd_font !== 8'hFF) begin
            n_err++; $display("FAIL range_d0: comm=%b font=%h required 1110 ff", o_fnd_comm, o_fnd_font);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (o_fnd_comm !== 4'b1101 || o_fnd_font !== 8'hFF) begin
            n_err++; $display("FAIL range_d1: comm=%b font=%h required 1101 ff", o_fnd_comm, o_fnd_font);
        end
    endtask

    task automatic test_reset_midframe();
        wait_frame();
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (o_fnd_comm !== 4'hF || o_fnd_font !== 8'hFF) begin
            n_err++; $display("FAIL midreset_dark: comm=%b font=%h required 1111 ff", o_fnd_comm, o_fnd_font);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_fnd_comm !== 4'b1110 || o_fnd_font !== 8'hC0) begin
            n_err++; $display("FAIL midreset_restart: comm=%b font=%h required 1110 c0", o_fnd_comm, o_fnd_font);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                i_msec = 7'($urandom_range(0, 127));
                i_sec  = 6'($urandom_range(0, 59));
                i_min  = 6'($urandom_range(0, 59));
                i_hour = 5'($urandom_range(0, 23));
                i_mode = 1'($urandom_range(0, 1));
            end
            n_cmp++;
            if (o_fnd_comm !== exp_comm || o_fnd_font !== exp_font) begin
                n_err++;
                $display("FAIL random_%0d: comm=%b font=%h required %b %h", i, o_fnd_comm, o_fnd_font, exp_comm, exp_font);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_midframe();
        test_dot_and_range();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
